mult_result_collector: RTL and testbench



---
 rtl/mult_result_collector.sv | 82 ++++++++
 tb/tb_mult_result_collector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_collector.sv
// mult_result_collector: captures multiplier products, acknowledges them and buffers them in a FWFT FIFO
module mult_result_collector #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iDone,
    input  logic [2*W-1:0]  iProduct,
    output logic            oAck,
    output logic            oValid,
    output logic [2*W-1:0]  oProduct,
    input  logic            iReady,
    output logic            oFull,
    output logic            oEmpty,
    output logic [AW:0]     oCount
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t         state;
    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [AW:0]    count;
    logic           push;
    logic           pop;
    // Capture only from IDLE and only when the registered count leaves room
    assign push     = (state == S_IDLE) && iDone && (count != FULL);
    assign pop      = oValid && iReady;
    assign oValid   = count != '0;
    assign oProduct = oValid ? mem[rdPtr] : '0;
    assign oFull    = count == FULL;
    assign oEmpty   = count == '0;
    assign oCount   = count;
    // Capture handshake: ack for one cycle, then hold off until iDone drops
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            oAck  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    oAck  <= push;
                    state <= push ? S_ACK : S_IDLE;
                end
                S_ACK: begin
                    oAck  <= 1'b0;
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    oAck  <= 1'b0;
                    state <= iDone ? S_RELEASE : S_IDLE;
                end
                default: begin
                    oAck  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Storage is not reset; only entries below count are ever presented
    always_ff @(posedge Clock) begin
        if (push) mem[wrPtr] <= iProduct;
    end
endmodule

// File: tb/tb_mult_result_collector.sv
// tb_mult_result_collector: table, directed and randomized checks against a queue-based model
module tb_mult_result_collector;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          iDone = 1'b0;
    logic          iReady = 1'b0;
    logic [63:0]   iProduct = '0;
    logic          oAck;
    logic          oValid;
    logic [63:0]   oProduct;
    logic          oFull;
    logic          oEmpty;
    logic [AW:0]   oCount;

    int tests = 0;
    int fails = 0;

    mult_result_collector #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clock(Clock), .Reset(Reset), .iDone(iDone), .iProduct(iProduct),
        .oAck(oAck), .oValid(oValid), .oProduct(oProduct), .iReady(iReady),
        .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Reference model: a queue of accepted products, updated from observed acks and pops
    logic [63:0] q[$];
    logic [63:0] rx[$];
    logic        prevPop = 1'b0;
    logic        prevAck = 1'b0;
    logic        prevDone = 1'b0;
    logic [63:0] prevProd = '0;

    always @(negedge Clock) begin
        if (!Reset) begin
            check("rst_ack", oAck, 0);
            check("rst_valid", oValid, 0);
            check("rst_product", oProduct, 0);
            check("rst_count", oCount, 0);
            check("rst_empty", oEmpty, 1);
            check("rst_full", oFull, 0);
            q.delete();
            prevPop = 1'b0;
            prevAck = 1'b0;
        end else begin
            if (prevPop && q.size() > 0) void'(q.pop_front());
            if (oAck) begin
                check("ack_needs_done", prevDone, 1);
                check("ack_spacing", prevAck, 0);
                check("ack_when_full", q.size() < DEPTH, 1);
                if (q.size() < DEPTH) q.push_back(prevProd);
            end
            check("mdl_count", oCount, q.size());
            check("mdl_valid", oValid, q.size() != 0);
            check("mdl_full", oFull, q.size() == DEPTH);
            check("mdl_empty", oEmpty, q.size() == 0);
            check("mdl_head", oProduct, q.size() != 0 ? q[0] : 64'd0);
            if (oValid && iReady) rx.push_back(oProduct);
            prevPop = oValid && iReady;
            prevAck = oAck;
        end
        prevDone = iDone;
        prevProd = iProduct;
    end

    typedef struct {
        logic        done;
        logic [63:0] prod;
        logic        rdy;
        logic        ack;
        logic [AW:0] cnt;
        logic [63:0] head;
    } vec_t;

    vec_t tbl[23];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rp;
        int acks;
        tbl = '{
            '{1, 1, 0, 1, 1, 1}, '{0, 1, 0, 0, 1, 1}, '{0, 1, 0, 0, 1, 1},
            '{1, 2, 0, 1, 2, 1}, '{0, 2, 0, 0, 2, 1}, '{0, 2, 0, 0, 2, 1},
            '{1, 3, 0, 1, 3, 1}, '{0, 3, 0, 0, 3, 1}, '{0, 3, 0, 0, 3, 1},
            '{1, 4, 0, 1, 4, 1}, '{0, 4, 0, 0, 4, 1}, '{0, 4, 0, 0, 4, 1},
            '{1, 5, 0, 0, 4, 1}, '{1, 5, 0, 0, 4, 1}, '{1, 5, 1, 0, 3, 2},
            '{1, 5, 0, 1, 4, 2}, '{0, 5, 0, 0, 4, 2}, '{0, 5, 1, 0, 3, 3},
            '{0, 5, 1, 0, 2, 4}, '{1, 6, 1, 1, 2, 5}, '{0, 6, 1, 0, 1, 6},
            '{0, 6, 1, 0, 0, 0}, '{0, 6, 0, 0, 0, 0}
        };

        // Reset held with a multiplier waiting in DONE
        rp = {$urandom, $urandom};
        iDone = 1'b1;
        iProduct = rp;
        repeat (3) tick();
        check("rst_hold_ack", oAck, 0);
        check("rst_hold_count", oCount, 0);
        Reset = 1'b1;
        tick();
        check("rst_rel_ack", oAck, 1);
        check("rst_rel_count", oCount, 1);
        check("rst_rel_product", oProduct, rp);
        iDone = 1'b0;
        tick();
        check("rst_rel_ack_low", oAck, 0);
        tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("rst_drain", oEmpty, 1);

        // Single capture, iDone dropped one cycle after the ack
        acks = 0;
        iDone = 1'b1;
        iProduct = 64'h0000_0003_0000_0005;
        tick();
        acks += int'(oAck);
        tick();
        acks += int'(oAck);
        iDone = 1'b0;
        repeat (3) begin
            tick();
            acks += int'(oAck);
        end
        check("single_acks", acks, 1);
        check("single_valid", oValid, 1);
        check("single_product", oProduct, 64'h0000_0003_0000_0005);
        check("single_count", oCount, 1);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;

        // iDone held long after the ack must not produce a second capture
        iDone = 1'b1;
        iProduct = 64'd7;
        tick();
        check("long_first_ack", oAck, 1);
        repeat (10) begin
            tick();
            check("long_no_ack", oAck, 0);
            check("long_count", oCount, 1);
        end
        iDone = 1'b0;
        repeat (2) tick();
        check("long_after_count", oCount, 1);
        check("long_after_ack", oAck, 0);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("long_drain", oEmpty, 1);

        // Fill, backpressure, pop-while-full and simultaneous push/pop
        for (int i = 0; i < 23; i++) begin
            iDone = tbl[i].done;
            iProduct = tbl[i].prod;
            iReady = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_ack", i), oAck, tbl[i].ack);
            check($sformatf("tbl%0d_count", i), oCount, tbl[i].cnt);
            check($sformatf("tbl%0d_head", i), oProduct, tbl[i].head);
            check($sformatf("tbl%0d_full", i), oFull, tbl[i].cnt == DEPTH);
        end

        // Randomized stream through pointer wrap
        rx.delete();
        fork
            begin
                for (int v = 100; v < 120; v++) begin
                    int n;
                    iDone = 1'b1;
                    iProduct = 64'(v);
                    n = 0;
                    do begin
                        tick();
                        n++;
                    end while (!oAck && n < 200);
                    check("stream_ack_timeout", oAck, 1);
                    repeat ($urandom_range(0, 3)) tick();
                    iDone = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                end
            end
            begin
                int n;
                n = 0;
                while (rx.size() < 20 && n < 4000) begin
                    iReady = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                end
                iReady = 1'b0;
                check("stream_drain_timeout", n < 4000, 1);
            end
        join
        repeat (2) tick();
        check("stream_rx_count", rx.size(), 20);
        for (int i = 0; i < rx.size(); i++) check($sformatf("stream_order%0d", i), rx[i], 64'(100 + i));
        check("stream_empty", oEmpty, 1);

        // Reset mid-operation discards buffered data
        iDone = 1'b1;
        iProduct = 64'd9;
        tick();
        iDone = 1'b0;
        repeat (2) tick();
        check("mid_count_before", oCount, 1);
        Reset = 1'b0;
        #1;
        check("mid_async_valid", oValid, 0);
        check("mid_async_count", oCount, 0);
        tick();
        Reset = 1'b1;
        tick();
        check("mid_after_empty", oEmpty, 1);
        check("mid_after_ack", oAck, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
